// File: rtl/ccd_raw_capture_if.sv
// Bundle of sensor-side inputs, capture controls and captured-pixel outputs for ccd_raw_capture.
//   CCD_DATA[9:0], CCD_FVAL, CCD_LVAL : raw Bayer pixel, frame valid, line valid from the sensor
//   iSTART, iEND                      : single-cycle capture start / stop requests
//   oDATA[9:0], oDVAL                 : captured pixel and its valid strobe
//   X_Cont[15:0], Y_Cont[15:0]        : pixel / line index of oDATA
//   oFRAME_CONT[31:0]                 : completed captured frames
//   oBUSY, oLEN_ERR                   : capture engine active, sticky line-length error
// Modport slave is the capture block's view; master is the view of whatever drives it.
interface ccd_raw_capture_if;
  logic [9:0]  CCD_DATA;
  logic        CCD_FVAL;
  logic        CCD_LVAL;
  logic        iSTART;
  logic        iEND;
  logic [9:0]  oDATA;
  logic        oDVAL;
  logic [15:0] X_Cont;
  logic [15:0] Y_Cont;
  logic [31:0] oFRAME_CONT;
  logic        oBUSY;
  logic        oLEN_ERR;

  modport master (
    output CCD_DATA, CCD_FVAL, CCD_LVAL, iSTART, iEND,
    input  oDATA, oDVAL, X_Cont, Y_Cont, oFRAME_CONT, oBUSY, oLEN_ERR
  );

  modport slave (
    input  CCD_DATA, CCD_FVAL, CCD_LVAL, iSTART, iEND,
    output oDATA, oDVAL, X_Cont, Y_Cont, oFRAME_CONT, oBUSY, oLEN_ERR
  );
endinterface

// File: rtl/ccd_raw_capture.sv
// Raw CCD capture front end: registers the sensor stream, gates whole frames under
// iSTART/iEND control and tags each captured pixel with its X/Y position.
// Ports:
//   CCD_PIXCLK : sole clock, rising edge
//   RST_N      : asynchronous active-low reset
//   bus        : ccd_raw_capture_if.slave (sensor inputs, controls, captured outputs)
// Parameters: X_MAX / Y_MAX are the last valid pixel / line index (counters saturate there).
// Optional feature: define CCD_CAPTURE_LEN_CHECK_EN to build the per-frame line-length
// check driving oLEN_ERR; otherwise oLEN_ERR is tied low.
// Outputs oDATA/oDVAL/X_Cont/Y_Cont trail the sensor inputs by exactly two clocks.
module ccd_raw_capture #(
  parameter logic [15:0] X_MAX = 16'd1279,
  parameter logic [15:0] Y_MAX = 16'd719
) (
  input logic              CCD_PIXCLK,
  input logic              RST_N,
  ccd_raw_capture_if.slave bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArmed   = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;
  localparam logic [1:0] StDrain   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [9:0]  data1_q, data1_d;
  logic        fval1_q, fval1_d, lval1_q, lval1_d;
  logic        fval2_q, fval2_d, lval2_q, lval2_d;
  logic [9:0]  data_q, data_d;
  logic        dval_q, dval_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [31:0] frame_q, frame_d;

  logic fval_rise, fval_fall, lval_fall;
  logic in_cap_q, in_cap_d;

  // Stage 1 samples the sensor; stage 2 keeps the previous FVAL/LVAL for edge detection.
  always_comb begin
    data1_d = bus.CCD_DATA;
    fval1_d = bus.CCD_FVAL;
    lval1_d = bus.CCD_LVAL;
    fval2_d = fval1_q;
    lval2_d = lval1_q;
  end

  assign fval_rise = fval1_q & ~fval2_q;
  assign fval_fall = ~fval1_q & fval2_q;
  assign lval_fall = ~lval1_q & lval2_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.iSTART && !bus.iEND) state_d = StArmed;
      end
      StArmed: begin
        if (bus.iEND)        state_d = StIdle;
        else if (fval_rise)  state_d = StCapture;
      end
      StCapture: begin
        // Stop inside a frame lets it finish; stop between frames ends at once.
        if (bus.iEND) state_d = fval1_q ? StDrain : StIdle;
      end
      StDrain: begin
        if (fval_fall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_cap_q = (state_q == StCapture) || (state_q == StDrain);
  // Next state is used so the first pixel of a frame coinciding with the FVAL rise is kept.
  assign in_cap_d = (state_d == StCapture) || (state_d == StDrain);

  always_comb begin
    dval_d  = lval1_q & fval1_q & in_cap_d;
    data_d  = dval_d ? data1_q : data_q;

    x_d = x_q;
    if (lval_fall)                 x_d = 16'd0;
    else if (dval_q && x_q < X_MAX) x_d = x_q + 16'd1;

    y_d = y_q;
    if (fval_rise)                                            y_d = 16'd0;
    else if (lval_fall && fval1_q && in_cap_q && y_q < Y_MAX) y_d = y_q + 16'd1;

    frame_d = frame_q;
    if (fval_fall && in_cap_q) frame_d = frame_q + 32'd1;
  end

  always_ff @(posedge CCD_PIXCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      data1_q <= '0;
      fval1_q <= 1'b0;
      lval1_q <= 1'b0;
      fval2_q <= 1'b0;
      lval2_q <= 1'b0;
      data_q  <= '0;
      dval_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      data1_q <= data1_d;
      fval1_q <= fval1_d;
      lval1_q <= lval1_d;
      fval2_q <= fval2_d;
      lval2_q <= lval2_d;
      data_q  <= data_d;
      dval_q  <= dval_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
    end
  end

  assign bus.oDATA       = data_q;
  assign bus.oDVAL       = dval_q;
  assign bus.X_Cont      = x_q;
  assign bus.Y_Cont      = y_q;
  assign bus.oFRAME_CONT = frame_q;
  assign bus.oBUSY       = (state_q != StIdle);

`ifdef CCD_CAPTURE_LEN_CHECK_EN
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] ref_len_q, ref_len_d;
  logic        first_line_q, first_line_d;
  logic        len_err_q, len_err_d;
  logic [15:0] line_len;
  logic        line_done;

  // Length of the line ending now includes the pixel still sitting in the output stage.
  assign line_len  = pix_cnt_q + {15'd0, dval_q};
  // Only lines that produced captured pixels take part in the check.
  assign line_done = lval_fall && (line_len != 16'd0);

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    ref_len_d    = ref_len_q;
    first_line_d = first_line_q;
    len_err_d    = len_err_q;
    if (lval_fall)   pix_cnt_d = 16'd0;
    else if (dval_q) pix_cnt_d = pix_cnt_q + 16'd1;
    if (line_done) begin
      if (first_line_q)             ref_len_d = line_len;
      else if (line_len != ref_len_q) len_err_d = 1'b1;
    end
    if (fval_rise)      first_line_d = 1'b1;
    else if (line_done) first_line_d = 1'b0;
  end

  always_ff @(posedge CCD_PIXCLK or negedge RST_N) begin
    if (!RST_N) begin
      pix_cnt_q    <= '0;
      ref_len_q    <= '0;
      first_line_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      ref_len_q    <= ref_len_d;
      first_line_q <= first_line_d;
      len_err_q    <= len_err_d;
    end
  end

  assign bus.oLEN_ERR = len_err_q;
`else
  assign bus.oLEN_ERR = 1'b0;
`endif

endmodule
